piso_4_bits_tx: RTL and testbench

Parallel-in, serial-out transmitter that feeds the 4-bit bidirectional serial shift register (SSBR_4_bits). It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on D, LSB-first or MSB-first. It also drives the companion dir line, so a downstream SSBR_4_bits reconstructs the word at QR or QL. It replaces hand-sequenced bench/driver stimulus for the serial path.

---
 rtl/piso_tx_pkg.sv | 14 +
 rtl/piso_4_bits_tx.sv | 111 +++++++++++
 tb/tb_piso_4_bits_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the 4-bit PISO serial transmitter.
// State encoding and default frame geometry.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 0;

endpackage

// File: rtl/piso_4_bits_tx.sv
// Parallel-in serial-out transmitter feeding a 4-bit bidirectional
// shift register; valid/ready word intake, one bit per clock on D.
module piso_4_bits_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       dir_in,
    input  logic                       valid,
    output logic                       ready,
    output logic                       D,
    output logic                       dir,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_idx
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST    = IW'(WIDTH - 1);
    localparam logic [3:0]    GAP_END = 4'(GAP - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              d_q, d_d;
    logic              dir_q, dir_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        gcnt_q, gcnt_d;

    logic              last;
    logic              accept;
    logic [IW-1:0]     nxt;
    logic [IW-1:0]     pos;

    assign busy    = (state_q == S_SHIFT);
    assign last    = busy && (idx_q == LAST);
    assign done    = last;
    assign ready   = rst_n && ((state_q == S_IDLE) || (last && (GAP == 0)));
    assign accept  = valid && ready;
    assign D       = d_q;
    assign dir     = dir_q;
    assign bit_idx = idx_q;

    // Next bit position in the held word, counted in transmit order
    assign nxt = idx_q + 1'b1;
    assign pos = dir_q ? nxt : (LAST - nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            d_q     <= 1'b0;
            dir_q   <= 1'b1;
            idx_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            d_q     <= d_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        d_d     = 1'b0;
        dir_d   = dir_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;

        unique case (state_q)
            S_IDLE: begin
            end
            S_SHIFT: begin
                if (!last) begin
                    idx_d = nxt;
                    d_d   = shreg_q[pos];
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gcnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_END) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance only happens in IDLE or on a gapless last bit
        if (accept) begin
            state_d = S_SHIFT;
            shreg_d = data_in;
            dir_d   = dir_in;
            idx_d   = '0;
            d_d     = dir_in ? data_in[0] : data_in[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_piso_4_bits_tx.sv
// Bench for piso_4_bits_tx: GAP=0 and GAP=2 instances checked each
// cycle against a per-frame output timeline model.
module tb_piso_4_bits_tx;

    localparam int W = 4;

    typedef struct packed {
        logic       d;
        logic       bsy;
        logic       dn;
        logic [1:0] idx;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din   [2];
    logic         dirin [2];
    logic         vld   [2];
    logic         rdy   [2];
    logic         d_o   [2];
    logic         dir_o [2];
    logic         busy  [2];
    logic         done  [2];
    logic [1:0]   idx   [2];

    ent_t         tl  [2][16];
    int           n   [2];
    logic         mdir[2];
    logic [W:0]   sc  [2][64];
    int           sh  [2];
    int           st  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_4_bits_tx #(.WIDTH(W), .GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .dir_in(dirin[0]),
        .valid(vld[0]), .ready(rdy[0]), .D(d_o[0]), .dir(dir_o[0]),
        .busy(busy[0]), .done(done[0]), .bit_idx(idx[0])
    );

    piso_4_bits_tx #(.WIDTH(W), .GAP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .dir_in(dirin[1]),
        .valid(vld[1]), .ready(rdy[1]), .D(d_o[1]), .dir(dir_o[1]),
        .busy(busy[1]), .done(done[1]), .bit_idx(idx[1])
    );

    function automatic int gap_of(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic mready(int i);
        logic lastbit;
        lastbit = (n[i] == 1) && tl[i][0].bsy && (tl[i][0].idx == 2'(W - 1));
        return rst_n && ((n[i] == 0) || ((gap_of(i) == 0) && lastbit));
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(int i, logic [W-1:0] w, logic dr);
        sc[i][st[i]] = {dr, w};
        st[i]++;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic acc;
            logic [W-1:0] w;
            logic dr;
            acc = vld[i] && mready(i);
            if (!rst_n) begin
                n[i]    = 0;
                mdir[i] = 1'b1;
            end else begin
                if (n[i] > 0) begin
                    for (int k = 0; k < 15; k++) tl[i][k] = tl[i][k+1];
                    n[i]--;
                end
                if (acc) begin
                    w  = sc[i][sh[i]][W-1:0];
                    dr = sc[i][sh[i]][W];
                    sh[i]++;
                    if (sh[i] == st[i]) begin
                        sh[i] = 0;
                        st[i] = 0;
                    end
                    mdir[i] = dr;
                    for (int k = 0; k < W; k++) begin
                        tl[i][n[i]] = '{d: dr ? w[k] : w[W-1-k], bsy: 1'b1,
                                        dn: (k == W - 1), idx: 2'(k)};
                        n[i]++;
                    end
                    for (int g = 0; g < gap_of(i); g++) begin
                        tl[i][n[i]] = '0;
                        n[i]++;
                    end
                end
            end
            if (!rst_n) check($sformatf("rst_idx%0d", i), 32'(idx[i]), 0);
            if (n[i] > 0) begin
                check($sformatf("d%0d", i),    32'(d_o[i]),  32'(tl[i][0].d));
                check($sformatf("busy%0d", i), 32'(busy[i]), 32'(tl[i][0].bsy));
                check($sformatf("done%0d", i), 32'(done[i]), 32'(tl[i][0].dn));
                if (tl[i][0].bsy)
                    check($sformatf("idx%0d", i), 32'(idx[i]), 32'(tl[i][0].idx));
            end else begin
                check($sformatf("d_idle%0d", i),    32'(d_o[i]),  0);
                check($sformatf("busy_idle%0d", i), 32'(busy[i]), 0);
                check($sformatf("done_idle%0d", i), 32'(done[i]), 0);
            end
            check($sformatf("dir%0d", i),   32'(dir_o[i]), 32'(mdir[i]));
            check($sformatf("ready%0d", i), 32'(rdy[i]),   32'(mready(i)));
            if (sh[i] != st[i]) begin
                vld[i]   = 1'b1;
                din[i]   = sc[i][sh[i]][W-1:0];
                dirin[i] = sc[i][sh[i]][W];
            end else begin
                vld[i]   = 1'b0;
                din[i]   = W'($urandom);
                dirin[i] = 1'($urandom);
            end
        end
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; mdir[i] = 1'b1; sh[i] = 0; st[i] = 0;
            vld[i] = 1'b0; din[i] = '0; dirin[i] = 1'b0;
        end
        repeat (2) step();
        rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            push(i, 4'b0100, 1'b1);
            push(i, 4'b0100, 1'b0);
            push(i, 4'hA, 1'b1);
            push(i, 4'h5, 1'b1);
        end
        repeat (40) step();

        for (int i = 0; i < 2; i++) push(i, 4'hF, 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            step();
            if (n[0] > 0 && tl[0][0].bsy && tl[0][0].idx == 2'd2) hit = 1'b1;
        end
        check("rst_wait", 32'(hit), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                if (sh[i] == st[i] && $urandom_range(0, 2) == 0)
                    push(i, W'($urandom), 1'($urandom));
            step();
        end
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
